lsu_mem: RTL
============

# lsu_mem

Parametrised byte-addressed data memory with an integrated load/store datapath for the MIPS core's MEM stage. It accepts byte, halfword and word accesses at byte addresses and aligns the data to the correct byte lanes. Loads are sign- or zero-extended. Misaligned accesses are flagged. A multi-cycle clear sweep replaces the single-cycle whole-array clear, so the array maps onto block RAM.

## Interface
Parameters:
- ADDR_BITS, 10, word-address width; DEPTH = 2^ADDR_BITS words
- LANES, 4, bytes per word, a power of two, at least 2; word width W = 8*LANES; OFF = log2(LANES)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  access request
- we  in  1  1 = store, 0 = load; sampled with req
- addr  in  ADDR_BITS+OFF  byte address; the low OFF bits are the lane offset
- size  in  2  access size of 2^size bytes (0 = byte, 1 = half, 2 = word, 3 = dword when LANES = 8)
- sext  in  1  on loads: 1 = sign-extend, 0 = zero-extend
- wdata  in  W  store data, right-justified (low bytes used)
- clr  in  1  one-cycle pulse that starts the clear sweep
- ready  out  1  a request is accepted this cycle
- rvalid  out  1  one-cycle pulse: load or error result is valid
- rdata  out  W  load result, right-justified and extended
- err  out  1  pulses with the response of a misaligned or oversize access
- busy  out  1  clear sweep in progress

## Operation
- FSM states:
  - IDLE: ready = !clr.
  - CLEAR: ready = 0, busy = 1.
- Acceptance: a request is accepted on a rising edge with req && ready.
- Error check: an access is bad if 2^size > LANES or addr[OFF-1:0] is not a multiple of 2^size.
- Good store: lanes offset .. offset+2^size-1 of word addr[top:OFF] take wdata bytes 0 .. 2^size-1. Other lanes are unchanged. rvalid stays 0 and err stays 0.
- Good load: the selected bytes are shifted to bit 0 and extended to W. Extension uses the top selected bit if sext = 1, otherwise zeros.
- Bad access (load or store): the memory is not written. On the next cycle rvalid = 1, err = 1 and rdata = 0.
- A size-W load ignores sext.
- clr in IDLE moves the FSM to CLEAR with counter = 0. clr wins over a same-cycle req; that req is not accepted, and the requester holds it.
- In CLEAR, each cycle writes 0 to word[counter] and increments the counter. After writing word DEPTH-1 the FSM returns to IDLE.
- clr pulses during CLEAR are ignored.
- Memory contents are not affected by rst; they are undefined until the first clear or write.

## Timing
- Reset values: state IDLE, counter 0, rvalid 0, err 0, busy 0, rdata 0. After reset, ready = 1 whenever clr = 0.
- Load latency is 1 cycle: accepted at edge N, rdata, rvalid and err are valid after edge N+1. Memory is read synchronously.
- Store latency is 1 cycle: the write commits at the accepting edge.
- Back-to-back: a request can be accepted every cycle. A load one cycle after a store to the same word returns the stored data.
- rdata holds the last load or error result until the next response. rvalid and err are single-cycle pulses.
- Clear sweep: busy is high for exactly DEPTH cycles, starting the cycle after the clr edge. ready goes high in the first IDLE cycle.
- rst mid-sweep: the FSM goes to IDLE immediately, busy drops asynchronously, and partially cleared contents are kept.
- rst during a pending load response: rvalid is forced to 0 and the response is lost.

## Test plan
Scenarios use ADDR_BITS = 4 and LANES = 4.
1. Word round trip: rst, store word 0xDEADBEEF at addr 0x10, then load word at 0x10 → one cycle later rvalid = 1, rdata = 0xDEADBEEF, err = 0.
2. Byte store and extended loads (word at 0x10 holds 0xDEADBEEF):
   - store byte 0x11 at 0x11, then load word at 0x10 → 0xDEAD11EF
   - load byte at 0x13, sext = 1 → 0xFFFFFFDE
   - load byte at 0x13, sext = 0 → 0x000000DE
   - load half at 0x12, sext = 1 → 0xFFFFDEAD
3. Misalignment:
   - load word at 0x12 → rvalid = 1, err = 1, rdata = 0
   - store half at 0x11 → err pulse; a following load word at 0x10 is unchanged
   - size = 3 load → err = 1
4. Clear sweep: fill all 16 words with nonzero data, pulse clr → busy high for 16 cycles, ready = 0, and a held req is not accepted until IDLE. Afterwards loads of every word return 0.
5. Reset mid-clear: pulse clr, assert rst at sweep cycle 5 → busy = 0 immediately. After release, ready = 1, words 0-4 read 0, and words 5-15 keep their old data.
6. Simultaneous events: clr and a store req in the same IDLE cycle → ready = 0, the store is not accepted, and the sweep runs. Back-to-back store and load to the same word on consecutive cycles → the load returns the new data.

Source files
------------

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: request/response bus between the MEM stage and the data memory
interface lsu_mem_if #(
    parameter int ADDR_BITS = 10,
    parameter int LANES     = 4
);
    localparam int W   = 8 * LANES;
    localparam int OFF = $clog2(LANES);
    logic                     req;
    logic                     we;
    logic [ADDR_BITS+OFF-1:0] addr;
    logic [1:0]               size;
    logic                     sext;
    logic [W-1:0]             wdata;
    logic                     clr;
    logic                     ready;
    logic                     rvalid;
    logic [W-1:0]             rdata;
    logic                     err;
    logic                     busy;
    modport master (output req, we, addr, size, sext, wdata, clr, input ready, rvalid, rdata, err, busy);
    modport slave  (input req, we, addr, size, sext, wdata, clr, output ready, rvalid, rdata, err, busy);
endinterface

// File: rtl/lsu_mem.sv
// lsu_mem: byte-addressed data memory with lane alignment, load extension and a clear sweep
module lsu_mem #(
    parameter int ADDR_BITS = 10,
    parameter int LANES     = 4
) (
    input  logic     clk,
    input  logic     rst,
    lsu_mem_if.slave bus
);
    localparam int W     = 8 * LANES;
    localparam int OFF   = $clog2(LANES);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t               state, state_n;
    logic [ADDR_BITS-1:0] cnt, cnt_n, idx, wa;
    logic [W-1:0]         mem [DEPTH];
    logic [W-1:0]         q, wd, sh, rd;
    logic [LANES-1:0]     be;
    logic [OFF-1:0]       off, r_off;
    logic [1:0]           r_size;
    logic                 r_sext, r_ok, rv, er;
    logic                 acc, bad, resp;
    int                   nb;

    assign idx        = bus.addr[ADDR_BITS+OFF-1:OFF];
    assign off        = bus.addr[OFF-1:0];
    assign bad        = (int'(bus.size) > OFF) || ((int'(off) & ((1 << bus.size) - 1)) != 0);
    assign bus.ready  = (state == IDLE) && !bus.clr;
    assign bus.busy   = (state == CLEAR);
    assign acc        = bus.req && bus.ready;
    assign resp       = acc && (!bus.we || bad);
    assign bus.rvalid = rv;
    assign bus.err    = er;
    assign bus.rdata  = rd;
    assign nb         = 8 << r_size;

    // FSM state and sweep counter; reset aborts a sweep and leaves memory as is
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // next state: clr starts the sweep, the last word returns to IDLE
    always_comb begin
        state_n = (state == IDLE && bus.clr) ? CLEAR :
                  (state == CLEAR && cnt == ADDR_BITS'(DEPTH - 1)) ? IDLE : state;
        cnt_n   = (state == CLEAR) ? cnt + 1'b1 : '0;
    end

    // single write port shared by the sweep and good stores, with byte enables
    always_comb begin
        wa = (state == CLEAR) ? cnt : idx;
        wd = (state == CLEAR) ? '0 : bus.wdata << {off, 3'b000};
        be = '0;
        for (int l = 0; l < LANES; l++)
            be[l] = (state == CLEAR) ||
                    (acc && bus.we && !bad && l >= int'(off) && l < int'(off) + (1 << bus.size));
    end

    // memory array: byte-enabled write and synchronous word read, no reset
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++)
            if (be[l]) mem[wa][8*l +: 8] <= wd[8*l +: 8];
        if (acc && !bus.we) q <= mem[idx];
    end

    // response pulse and the lane/extension info needed to shape the read word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv     <= 1'b0;
            er     <= 1'b0;
            r_ok   <= 1'b0;
            r_off  <= '0;
            r_size <= '0;
            r_sext <= 1'b0;
        end else begin
            rv <= resp;
            er <= acc && bad;
            if (resp) r_ok <= !bad;
            if (resp && !bad) begin
                r_off  <= off;
                r_size <= bus.size;
                r_sext <= bus.sext;
            end
        end
    end

    // shift the selected bytes to bit 0 and extend; error responses read as zero
    always_comb begin
        sh = q >> {r_off, 3'b000};
        rd = '0;
        for (int i = 0; i < W; i++)
            rd[i] = r_ok && ((i < nb) ? sh[i] : (r_sext && sh[nb-1]));
    end
endmodule
